// File: rtl/axi4lite_pkg.sv
// ---------------------------------------------------------------------------
// axi4lite_pkg
//
// Shared definitions for the AXI4-Lite blocks: default bus widths, the
// write/read channel state types used by the slave memory, and a small
// helper that converts a data width into the number of byte-offset bits
// that sit below the word index in a byte address.
//
// Contents:
//    ADDRWIDTH         default AXI4-Lite address width
//    DATAWIDTH         default AXI4-Lite data width (multiple of 8)
//    wr_state_t        write channel states (W_IDLE, W_RESP)
//    rd_state_t        read channel states  (R_IDLE, R_DATA)
//    byteOffsetBits()  log2 of the number of bytes in one data word
// ---------------------------------------------------------------------------
package axi4lite_pkg;

   localparam int ADDRWIDTH = 32;
   localparam int DATAWIDTH = 32;

   // Write channel: waiting for address/data, or presenting the B response.
   typedef enum logic {W_IDLE, W_RESP} wr_state_t;

   // Read channel: waiting for an address, or presenting the R data beat.
   typedef enum logic {R_IDLE, R_DATA} rd_state_t;

   // Byte addresses carry this many low bits that select a byte inside a
   // word; the word index starts right above them.
   function automatic int byteOffsetBits(input int dataWidth);
      return $clog2(dataWidth / 8);
   endfunction

endpackage

// File: rtl/axi4lite_mem_array.sv
// ---------------------------------------------------------------------------
// axi4lite_mem_array
//
// DEPTH x DATAWIDTH word storage behind the AXI4-Lite slave. One synchronous
// write port, one registered read port, and a synchronous clear of every
// word (and of the read register) while reset is high.
//
// The read register samples the array contents as they were before the
// clock edge, so a read and a write to the same word on the same edge
// return the old value.
//
// Ports:
//    i_clk        clock, all logic on its rising edge
//    i_reset      synchronous active-high clear
//    i_wrEn       write strobe
//    i_wrIdx      word index to write
//    i_wrData     data to write
//    i_rdEn       load the read register on this edge
//    i_rdInRange  the read address decodes inside the array; if low the
//                 read register loads zero instead of array data
//    i_rdIdx      word index to read
//    o_rdData     registered read data, held until the next i_rdEn
// ---------------------------------------------------------------------------
module axi4lite_mem_array
   import axi4lite_pkg::*;
#(
   parameter int DATAWIDTH = axi4lite_pkg::DATAWIDTH,
   parameter int DEPTH     = 16,
   parameter int IDXW      = $clog2(DEPTH)
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_wrEn,
   input  logic [IDXW-1:0]      i_wrIdx,
   input  logic [DATAWIDTH-1:0] i_wrData,
   input  logic                 i_rdEn,
   input  logic                 i_rdInRange,
   input  logic [IDXW-1:0]      i_rdIdx,
   output logic [DATAWIDTH-1:0] o_rdData
);

   logic [DATAWIDTH-1:0] r_mem [DEPTH];
   logic [DATAWIDTH-1:0] r_rdData;

   // Storage write port. Reset wins over a write on the same edge, so a
   // transaction interrupted by reset never lands in memory.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_wrEn) begin
         r_mem[i_wrIdx] <= i_wrData;
      end
   end

   // Registered read port. The register only changes when a new read is
   // accepted, which keeps the data stable while the response is stalled.
   // Addresses outside the array read back as zero.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rdData <= '0;
      end else if (i_rdEn) begin
         r_rdData <= i_rdInRange ? r_mem[i_rdIdx] : '0;
      end
   end

   assign o_rdData = r_rdData;

endmodule

// File: rtl/axi4lite_slave_mem.sv
// ---------------------------------------------------------------------------
// axi4lite_slave_mem
//
// AXI4-Lite responder backed by a small word-addressed memory. The write and
// read channels run as independent state machines, so one write and one read
// can be outstanding at the same time.
//
// Address decode: the word index is taken from the byte address just above
// the byte-offset bits; any set bit above the index marks the access as out
// of range. Out-of-range writes are acknowledged and dropped, out-of-range
// reads return zero.
//
// Ports:
//    ACLK      clock, all logic on its rising edge
//    ARESET    synchronous active-high reset
//    AWADDR    write address          AWVALID / AWREADY  address handshake
//    WDATA     write data             WVALID  / WREADY   data handshake
//    BVALID    write response valid   BREADY             response accept
//    ARADDR    read address           ARVALID / ARREADY  address handshake
//    RDATA     read data              RVALID  / RREADY   data handshake
// ---------------------------------------------------------------------------
module axi4lite_slave_mem #(
   parameter int ADDRWIDTH = axi4lite_pkg::ADDRWIDTH,
   parameter int DATAWIDTH = axi4lite_pkg::DATAWIDTH,
   parameter int DEPTH     = 16
) (
   input  logic                 ACLK,
   input  logic                 ARESET,
   input  logic [ADDRWIDTH-1:0] AWADDR,
   input  logic                 AWVALID,
   output logic                 AWREADY,
   input  logic [DATAWIDTH-1:0] WDATA,
   input  logic                 WVALID,
   output logic                 WREADY,
   output logic                 BVALID,
   input  logic                 BREADY,
   input  logic [ADDRWIDTH-1:0] ARADDR,
   input  logic                 ARVALID,
   output logic                 ARREADY,
   output logic [DATAWIDTH-1:0] RDATA,
   output logic                 RVALID,
   input  logic                 RREADY
);

   import axi4lite_pkg::*;

   localparam int B    = byteOffsetBits(DATAWIDTH);
   localparam int IDXW = $clog2(DEPTH);
   localparam int TOPB = IDXW + B;

   wr_state_t            r_wrState;
   rd_state_t            r_rdState;

   logic                 r_awHeld;
   logic                 r_wHeld;
   logic [ADDRWIDTH-1:0] r_awAddr;
   logic [DATAWIDTH-1:0] r_wData;

   logic                 w_awHs;
   logic                 w_wHs;
   logic                 w_haveAddr;
   logic                 w_haveData;
   logic                 w_commit;
   logic [ADDRWIDTH-1:0] w_wrAddr;
   logic [DATAWIDTH-1:0] w_wrData;
   logic                 w_wrInRange;
   logic                 w_arHs;
   logic                 w_rdInRange;
   logic [IDXW-1:0]      w_wrIdx;
   logic [IDXW-1:0]      w_rdIdx;

   // Channel readies. The write side stops accepting a half once it holds
   // that half, and both sides drop all readies while reset is asserted.
   assign AWREADY = (r_wrState == W_IDLE) && !r_awHeld && !ARESET;
   assign WREADY  = (r_wrState == W_IDLE) && !r_wHeld  && !ARESET;
   assign ARREADY = (r_rdState == R_IDLE) && !ARESET;

   // Response valids are pure state decodes, so they are glitch-free and
   // only fall when the state machine sees the matching ready.
   assign BVALID  = (r_wrState == W_RESP);
   assign RVALID  = (r_rdState == R_DATA);

   assign w_awHs  = AWVALID && AWREADY;
   assign w_wHs   = WVALID  && WREADY;
   assign w_arHs  = ARVALID && ARREADY;

   // A write half is available if it was captured earlier or is being
   // handed over on this very edge; the commit can then use the live bus
   // value instead of waiting a cycle for the holding register.
   assign w_haveAddr = r_awHeld || w_awHs;
   assign w_haveData = r_wHeld  || w_wHs;
   assign w_wrAddr   = r_awHeld ? r_awAddr : AWADDR;
   assign w_wrData   = r_wHeld  ? r_wData  : WDATA;
   assign w_commit   = (r_wrState == W_IDLE) && w_haveAddr && w_haveData;

   // Decode: everything above the index bits must be zero for the access
   // to land inside the array.
   assign w_wrInRange = (w_wrAddr >> TOPB) == '0;
   assign w_rdInRange = (ARADDR   >> TOPB) == '0;
   assign w_wrIdx     = w_wrAddr[TOPB-1:B];
   assign w_rdIdx     = ARADDR[TOPB-1:B];

   // Write channel. In W_IDLE the address and data halves are captured in
   // any order; as soon as both are present the memory write happens and
   // the response is raised on the same edge. The held flags stay set
   // through W_RESP and are cleared together when the response is taken.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_wrState <= W_IDLE;
         r_awHeld  <= 1'b0;
         r_wHeld   <= 1'b0;
         r_awAddr  <= '0;
         r_wData   <= '0;
      end else begin
         case (r_wrState)
            W_IDLE: begin
               if (w_awHs) begin
                  r_awHeld <= 1'b1;
                  r_awAddr <= AWADDR;
               end
               if (w_wHs) begin
                  r_wHeld <= 1'b1;
                  r_wData <= WDATA;
               end
               if (w_commit) begin
                  r_wrState <= W_RESP;
               end
            end
            W_RESP: begin
               if (BREADY) begin
                  r_wrState <= W_IDLE;
                  r_awHeld  <= 1'b0;
                  r_wHeld   <= 1'b0;
               end
            end
         endcase
      end
   end

   // Read channel. An accepted address loads the read register on the same
   // edge that raises RVALID; the beat is then held until RREADY.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_rdState <= R_IDLE;
      end else begin
         case (r_rdState)
            R_IDLE: begin
               if (w_arHs) begin
                  r_rdState <= R_DATA;
               end
            end
            R_DATA: begin
               if (RREADY) begin
                  r_rdState <= R_IDLE;
               end
            end
         endcase
      end
   end

   // Storage. The write enable drops out-of-range commits so they are
   // acknowledged without touching memory.
   axi4lite_mem_array #(
      .DATAWIDTH (DATAWIDTH),
      .DEPTH     (DEPTH),
      .IDXW      (IDXW)
   ) u_memArray (
      .i_clk       (ACLK),
      .i_reset     (ARESET),
      .i_wrEn      (w_commit && w_wrInRange),
      .i_wrIdx     (w_wrIdx),
      .i_wrData    (w_wrData),
      .i_rdEn      (w_arHs),
      .i_rdInRange (w_rdInRange),
      .i_rdIdx     (w_rdIdx),
      .o_rdData    (RDATA)
   );

endmodule

// File: tb/tb_axi4lite_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_axi4lite_slave_mem
//
// Directed and randomized traffic against axi4lite_slave_mem. Expected read
// data comes from a plain word array indexed by byte address / 4, updated
// whenever a write to an address below DEPTH*4 completes.
// ---------------------------------------------------------------------------
module tb_axi4lite_slave_mem;

   localparam int          DEPTH = 16;
   localparam logic [31:0] LIMIT = DEPTH * 4;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic [31:0] AWADDR = '0;
   logic        AWVALID = 1'b0;
   logic        AWREADY;
   logic [31:0] WDATA = '0;
   logic        WVALID = 1'b0;
   logic        WREADY;
   logic        BVALID;
   logic        BREADY = 1'b1;
   logic [31:0] ARADDR = '0;
   logic        ARVALID = 1'b0;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic        RVALID;
   logic        RREADY = 1'b1;

   int          total = 0;
   int          bad = 0;
   logic [31:0] modelMem [DEPTH];

   axi4lite_slave_mem #(
      .ADDRWIDTH (32),
      .DATAWIDTH (32),
      .DEPTH     (DEPTH)
   ) dut (
      .ACLK    (ACLK),
      .ARESET  (ARESET),
      .AWADDR  (AWADDR),
      .AWVALID (AWVALID),
      .AWREADY (AWREADY),
      .WDATA   (WDATA),
      .WVALID  (WVALID),
      .WREADY  (WREADY),
      .BVALID  (BVALID),
      .BREADY  (BREADY),
      .ARADDR  (ARADDR),
      .ARVALID (ARVALID),
      .ARREADY (ARREADY),
      .RDATA   (RDATA),
      .RVALID  (RVALID),
      .RREADY  (RREADY)
   );

   // Free-running 10-unit clock.
   always #5 ACLK = ~ACLK;

   // Hard stop in case something stalls beyond every per-transaction bound.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: counts it, and on a miss counts and reports it.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drive all three request channels at once.
   task automatic applyStimulus(input logic awv, input logic [31:0] awa, input logic wv, input logic [31:0] wd,
                                input logic arv, input logic [31:0] ara);
      AWVALID = awv;
      AWADDR  = awa;
      WVALID  = wv;
      WDATA   = wd;
      ARVALID = arv;
      ARADDR  = ara;
   endtask

   // Advance one clock; returns just after the following falling edge.
   task automatic tick();
      @(posedge ACLK);
      @(negedge ACLK);
      #1;
   endtask

   function automatic logic [31:0] modelRead(input logic [31:0] addr);
      if (addr < LIMIT) return modelMem[int'(addr / 4)];
      return 32'h0;
   endfunction

   task automatic modelWrite(input logic [31:0] addr, input logic [31:0] data);
      if (addr < LIMIT) modelMem[int'(addr / 4)] = data;
   endtask

   // Write with the data phase starting `lag` cycles after the address phase
   // (negative lag: address after data). Leaves the bench on the cycle where
   // BVALID must be high; with waitB and BREADY high, also sees it drop.
   task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input int lag,
                          input string tag, input bit waitB);
      int awStart;
      int wStart;
      int cyc;
      bit awDone;
      bit wDone;
      bit awHs;
      bit wHs;
      awStart = (lag < 0) ? -lag : 0;
      wStart  = (lag > 0) ? lag : 0;
      awDone  = 1'b0;
      wDone   = 1'b0;
      cyc     = 0;
      AWADDR  = addr;
      WDATA   = data;
      while (!(awDone && wDone) && cyc < 20) begin
         AWVALID = !awDone && (cyc >= awStart);
         WVALID  = !wDone && (cyc >= wStart);
         #1;
         checkOutput({tag, " bvalid before commit"}, 32'(BVALID), 32'd0);
         checkOutput({tag, " awready"}, 32'(AWREADY), awDone ? 32'd0 : 32'd1);
         checkOutput({tag, " wready"}, 32'(WREADY), wDone ? 32'd0 : 32'd1);
         awHs = AWVALID && AWREADY;
         wHs  = WVALID && WREADY;
         tick();
         awDone = awDone || awHs;
         wDone  = wDone || wHs;
         cyc++;
      end
      if (!(awDone && wDone)) checkOutput({tag, " handshake timeout"}, 32'd0, 32'd1);
      AWVALID = 1'b0;
      WVALID  = 1'b0;
      #1;
      checkOutput({tag, " bvalid"}, 32'(BVALID), 32'd1);
      checkOutput({tag, " awready in resp"}, 32'(AWREADY), 32'd0);
      modelWrite(addr, data);
      if (waitB && BREADY) begin
         tick();
         checkOutput({tag, " bvalid one cycle"}, 32'(BVALID), 32'd0);
         checkOutput({tag, " awready back"}, 32'(AWREADY), 32'd1);
      end
   endtask

   // Single read; with waitR and RREADY high, also checks RVALID drops.
   task automatic doRead(input logic [31:0] addr, input string tag, input bit waitR);
      logic [31:0] expected;
      expected = modelRead(addr);
      ARADDR   = addr;
      ARVALID  = 1'b1;
      #1;
      checkOutput({tag, " arready"}, 32'(ARREADY), 32'd1);
      checkOutput({tag, " rvalid before"}, 32'(RVALID), 32'd0);
      tick();
      ARVALID = 1'b0;
      #1;
      checkOutput({tag, " rvalid"}, 32'(RVALID), 32'd1);
      checkOutput({tag, " rdata"}, RDATA, expected);
      if (waitR && RREADY) begin
         tick();
         checkOutput({tag, " rvalid one cycle"}, 32'(RVALID), 32'd0);
      end
   endtask

   initial begin
      logic [31:0] oldVal;
      logic [31:0] heldData;
      logic [31:0] rAddr;
      logic [31:0] wAddr;
      int          lag;

      for (int i = 0; i < DEPTH; i++) modelMem[i] = 32'h0;

      // Reset state.
      repeat (3) @(negedge ACLK);
      #1;
      checkOutput("reset awready", 32'(AWREADY), 32'd0);
      checkOutput("reset wready", 32'(WREADY), 32'd0);
      checkOutput("reset arready", 32'(ARREADY), 32'd0);
      checkOutput("reset bvalid", 32'(BVALID), 32'd0);
      checkOutput("reset rvalid", 32'(RVALID), 32'd0);
      checkOutput("reset rdata", RDATA, 32'h0);
      ARESET = 1'b0;
      #1;
      checkOutput("post reset awready", 32'(AWREADY), 32'd1);
      checkOutput("post reset wready", 32'(WREADY), 32'd1);
      checkOutput("post reset arready", 32'(ARREADY), 32'd1);

      // Simultaneous AW/W, then read it back.
      doWrite(32'h04, 32'hDEADBEEF, 0, "w04", 1'b1);
      doRead(32'h04, "r04", 1'b1);
      checkOutput("r04 literal", modelRead(32'h04), 32'hDEADBEEF);

      // Address first, data three cycles later; then the reverse order.
      doWrite(32'h08, 32'h12345678, 3, "w08 aw first", 1'b1);
      doRead(32'h08, "r08a", 1'b1);
      doWrite(32'h08, 32'h0BADF00D, -3, "w08 w first", 1'b1);
      doRead(32'h08, "r08b", 1'b1);

      // Stalled write response: nothing new may be accepted.
      BREADY = 1'b0;
      doWrite(32'h10, 32'hCAFE0010, 0, "wstall", 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 32'h14, 1'b1, 32'h77777777, 1'b0, 32'h0);
         #1;
         checkOutput("wstall bvalid held", 32'(BVALID), 32'd1);
         checkOutput("wstall awready", 32'(AWREADY), 32'd0);
         checkOutput("wstall wready", 32'(WREADY), 32'd0);
         tick();
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      BREADY = 1'b1;
      tick();
      checkOutput("wstall released", 32'(BVALID), 32'd0);

      // Stalled read response: data held, no new address accepted.
      RREADY = 1'b0;
      doRead(32'h10, "rstall", 1'b0);
      heldData = modelRead(32'h10);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h14);
         #1;
         checkOutput("rstall rvalid held", 32'(RVALID), 32'd1);
         checkOutput("rstall rdata held", RDATA, heldData);
         checkOutput("rstall arready", 32'(ARREADY), 32'd0);
         tick();
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      RREADY = 1'b1;
      tick();
      checkOutput("rstall released", 32'(RVALID), 32'd0);
      doRead(32'h14, "r14 untouched", 1'b1);

      // Read captured on the commit edge of a write to the same word.
      oldVal = modelRead(32'h0C);
      applyStimulus(1'b1, 32'h0C, 1'b1, 32'hA5A5A5A5, 1'b1, 32'h0C);
      #1;
      checkOutput("coll awready", 32'(AWREADY), 32'd1);
      checkOutput("coll arready", 32'(ARREADY), 32'd1);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      checkOutput("coll bvalid", 32'(BVALID), 32'd1);
      checkOutput("coll rvalid", 32'(RVALID), 32'd1);
      checkOutput("coll rdata old", RDATA, oldVal);
      modelWrite(32'h0C, 32'hA5A5A5A5);
      tick();
      checkOutput("coll bvalid done", 32'(BVALID), 32'd0);
      checkOutput("coll rvalid done", 32'(RVALID), 32'd0);
      doRead(32'h0C, "coll new", 1'b1);

      // Out-of-range write is acknowledged and dropped; out-of-range read is 0.
      doWrite(LIMIT, 32'hFFFFFFFF, 0, "woor", 1'b1);
      doRead(LIMIT, "roor", 1'b1);
      doRead(32'h00, "r00 after oor", 1'b1);
      doRead(32'h3C, "r3c after oor", 1'b1);

      // Randomized traffic, mostly in range, with random AW/W ordering.
      for (int n = 0; n < 40; n++) begin
         wAddr = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(64, 32'hFFFF)) : 32'($urandom_range(0, 63));
         rAddr = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(64, 32'hFFFF)) : 32'($urandom_range(0, 63));
         lag   = int'($urandom_range(0, 6)) - 3;
         doWrite(wAddr, $urandom, lag, "rand write", 1'b1);
         doRead(rAddr, "rand read", 1'b1);
      end

      // Reset while both a B and an R response are pending.
      doWrite(32'h20, 32'h5555AAAA, 0, "wpre", 1'b1);
      BREADY = 1'b0;
      RREADY = 1'b0;
      doWrite(32'h24, 32'h13572468, 0, "wabort", 1'b0);
      doRead(32'h20, "rabort", 1'b0);
      ARESET = 1'b1;
      #1;
      checkOutput("mid reset awready", 32'(AWREADY), 32'd0);
      checkOutput("mid reset wready", 32'(WREADY), 32'd0);
      checkOutput("mid reset arready", 32'(ARREADY), 32'd0);
      tick();
      checkOutput("mid reset bvalid", 32'(BVALID), 32'd0);
      checkOutput("mid reset rvalid", 32'(RVALID), 32'd0);
      checkOutput("mid reset rdata", RDATA, 32'h0);
      checkOutput("mid reset arready held", 32'(ARREADY), 32'd0);
      ARESET = 1'b0;
      BREADY = 1'b1;
      RREADY = 1'b1;
      #1;
      checkOutput("after reset awready", 32'(AWREADY), 32'd1);
      checkOutput("after reset wready", 32'(WREADY), 32'd1);
      checkOutput("after reset arready", 32'(ARREADY), 32'd1);
      for (int i = 0; i < DEPTH; i++) modelMem[i] = 32'h0;
      doRead(32'h20, "r20 cleared", 1'b1);
      doRead(32'h24, "r24 cleared", 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
